sys_cmd_ctrl: RTL and testbench
===============================

# sys_cmd_ctrl

Command controller in the destination clock domain that consumes bytes from the data synchronizer: one byte on `rx_data` qualified by the single-cycle `rx_valid` (the synchronizer's `enable_pulse`). It parses fixed-format command frames, issues register-file writes and reads and ALU operations, and returns result bytes to the transmit path over a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 8, byte width; must match the synchronizer `BUS_WIDTH`.
- `ADDR_WIDTH`, 4, register-file address width.
- `FUN_WIDTH`, 4, ALU function code width.
- `CLK` input 1: single clock, destination domain.
- `RST` input 1: synchronous, active-low reset.
- `rx_data` input DATA_WIDTH: synchronized byte.
- `rx_valid` input 1: one-cycle strobe, `rx_data` valid.
- `rf_addr` output ADDR_WIDTH: register-file address.
- `rf_wr_en` output 1: one-cycle write strobe.
- `rf_wr_data` output DATA_WIDTH: write data.
- `rf_rd_en` output 1: one-cycle read strobe.
- `rf_rd_data` input DATA_WIDTH: read data.
- `rf_rd_valid` input 1: `rf_rd_data` valid.
- `alu_en` output 1: one-cycle ALU start.
- `alu_fun` output FUN_WIDTH: ALU function.
- `alu_out` input 2*DATA_WIDTH: ALU result.
- `alu_out_valid` input 1: `alu_out` valid.
- `tx_data` output DATA_WIDTH: response byte.
- `tx_valid` output 1: response byte pending.
- `tx_ready` input 1: transmitter accepts the byte.
- `frame_drop` output 1: one-cycle pulse when a byte is discarded.

## Operation
- Frame opcodes (first byte):
  - 0xAA write: addr, data.
  - 0xBB read: addr.
  - 0xCC ALU with operands: A, B, fun.
  - 0xDD ALU without operands: fun.
- Address bytes use the low ADDR_WIDTH bits. Function bytes use the low FUN_WIDTH bits.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_RD, TX_LO, TX_HI.
- **IDLE:** a valid opcode moves to WR_ADDR, RD_ADDR, OP_A or ALU_FUN. Any other byte is ignored silently, with no drop pulse.
- **Write path:**
  - WR_ADDR latches the address and moves to WR_DATA.
  - In WR_DATA, the next byte causes `rf_wr_en`=1 for one cycle with the latched address and that byte, then IDLE.
- **Operand path:**
  - OP_A byte writes register address 0, then moves to OP_B.
  - OP_B byte writes register address 1, then moves to ALU_FUN.
  - Each operand write is a one-cycle `rf_wr_en`.
- **ALU path:**
  - An ALU_FUN byte pulses `alu_en` for one cycle with `alu_fun` set, then moves to ALU_WAIT.
  - On `alu_out_valid`, the block latches `alu_out` and moves to TX_LO (low byte), then TX_HI (high byte), then IDLE.
- **Read path:**
  - An RD_ADDR byte pulses `rf_rd_en` for one cycle, then moves to RD_WAIT.
  - On `rf_rd_valid`, the block latches data and moves to TX_RD, then IDLE.
- **TX states:**
  - `tx_valid`=1 with `tx_data` stable.
  - The transfer completes in the cycle where `tx_valid` and `tx_ready` are both 1; the state advances on that edge.
- `rx_valid` arriving in RD_WAIT, ALU_WAIT or any TX state drops the byte and pulses `frame_drop`. It does not change state.
- There are no timeouts; a wait state holds until its valid input arrives.

## Timing
- Reset (`RST`=0 at a CLK edge): state IDLE. Every output is 0: `rf_addr`, `rf_wr_data`, `alu_fun`, `tx_data`, all strobes, `tx_valid` and `frame_drop`.
- Reset in mid-frame aborts the frame and clears any latched result. No strobe is issued after reset.
- All outputs are registered.
- A strobe caused by `rx_valid` at edge N is high during cycle N+1 only.
- A received byte is acted on one cycle after `rx_valid`.
- `tx_valid` rises in the cycle after the result is latched.
- A TX byte with `tx_ready` held high takes one cycle.
- Back-to-back `rx_valid` on consecutive cycles must be accepted in all parsing states.
- `rx_valid` and `alu_out_valid` in the same cycle: the result is latched and the byte is dropped.

## Structure
- Package `sys_cmd_pkg` holds:
  - opcode constants (0xAA, 0xBB, 0xCC, 0xDD);
  - operand addresses (A=0, B=1);
  - the state encoding.
- One natural sub-module is `resp_sender`: a one-byte holding register with the `tx_valid`/`tx_ready` handshake, loaded by the FSM.

## Test plan
- **Write:** AA, 05, 3C with strobes 4 cycles apart -> one `rf_wr_en` pulse with addr 5, data 0x3C. No `tx_valid`.
- **Read:** BB, 05, model returns 0x3C two cycles after `rf_rd_en` -> `tx_data`=0x3C. Hold `tx_ready`=0 for 3 cycles -> `tx_valid` held and data stable, then one transfer.
- **ALU with operands:** CC, 0A, 14, 00, model returns 0x00C8 -> writes addr0=0x0A and addr1=0x14, `alu_en` with fun 0, then TX 0xC8 followed by 0x00.
- **ALU without operands:** DD, 02 -> single `alu_en` with fun 2. Result 0x1234 transmitted as 0x34 then 0x12.
- **Drop and ignore:** byte 0x55 in IDLE -> no effect, no `frame_drop`. A byte arriving during ALU_WAIT -> one `frame_drop` pulse, and the frame still completes.
- **Reset mid-frame:** AA, 07, then `RST`=0 -> IDLE, all outputs 0. Following AA, 01, 99 writes addr 1 with 0x99.

Source files
------------

// File: rtl/sys_cmd_pkg.sv
// Shared definitions for the command controller: frame opcodes, the fixed
// operand register addresses and the parser state encoding.
package sys_cmd_pkg;

    localparam logic [7:0] OPC_WRITE   = 8'hAA;
    localparam logic [7:0] OPC_READ    = 8'hBB;
    localparam logic [7:0] OPC_ALU_OPS = 8'hCC;
    localparam logic [7:0] OPC_ALU_FUN = 8'hDD;

    localparam int OPERAND_A_ADDR = 0;
    localparam int OPERAND_B_ADDR = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OP_A,
        ST_OP_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_TX_RD,
        ST_TX_LO,
        ST_TX_HI
    } state_t;

    // States that wait on the register file, the ALU or the transmitter;
    // a byte arriving in one of them is discarded.
    function automatic logic drops_rx(input state_t s);
        return s inside {ST_RD_WAIT, ST_ALU_WAIT, ST_TX_RD, ST_TX_LO, ST_TX_HI};
    endfunction

endpackage

// File: rtl/sys_cmd_ctrl_if.sv
// Byte input, register-file, ALU and response signals of the command controller.
// master = controller side, slave = surrounding system.
interface sys_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0]   rx_data;
    logic                    rx_valid;
    logic [ADDR_WIDTH-1:0]   rf_addr;
    logic                    rf_wr_en;
    logic [DATA_WIDTH-1:0]   rf_wr_data;
    logic                    rf_rd_en;
    logic [DATA_WIDTH-1:0]   rf_rd_data;
    logic                    rf_rd_valid;
    logic                    alu_en;
    logic [FUN_WIDTH-1:0]    alu_fun;
    logic [2*DATA_WIDTH-1:0] alu_out;
    logic                    alu_out_valid;
    logic [DATA_WIDTH-1:0]   tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    frame_drop;

    modport master (
        input  rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_ready,
        output rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun, tx_data, tx_valid,
               frame_drop
    );

    modport slave (
        output rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_ready,
        input  rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun, tx_data, tx_valid,
               frame_drop
    );
endinterface

// File: rtl/sys_cmd_ctrl_resp_sender.sv
// One-byte response holding register: loaded by the parser, released to the
// transmitter on a tx_valid/tx_ready handshake.
module resp_sender #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  done
);
    assign done = tx_valid && tx_ready;

    // A load in the same cycle as a completed transfer queues the next byte
    // without a bubble, so tx_valid stays high.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            tx_data  <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            tx_data  <= load_data;
            tx_valid <= 1'b1;
        end else if (done) begin
            tx_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command frame parser: decodes write/read/ALU frames from the synchronized
// byte stream, drives the register file and ALU, and returns result bytes.
module sys_cmd_ctrl
    import sys_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic           CLK,
    input  logic           RST,
    sys_cmd_ctrl_if.master bus
);
    localparam logic [DATA_WIDTH-1:0] OPC_WR  = DATA_WIDTH'(OPC_WRITE);
    localparam logic [DATA_WIDTH-1:0] OPC_RD  = DATA_WIDTH'(OPC_READ);
    localparam logic [DATA_WIDTH-1:0] OPC_OPS = DATA_WIDTH'(OPC_ALU_OPS);
    localparam logic [DATA_WIDTH-1:0] OPC_FUN = DATA_WIDTH'(OPC_ALU_FUN);

    state_t                state;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic                  rf_wr_en;
    logic [DATA_WIDTH-1:0] rf_wr_data;
    logic                  rf_rd_en;
    logic                  alu_en;
    logic [FUN_WIDTH-1:0]  alu_fun;
    logic                  frame_drop;
    logic [DATA_WIDTH-1:0] alu_hi;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_done;

    // NOTE: every variable gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        load      = 1'b0;
        load_data = '0;
        case (state)
            ST_RD_WAIT: begin
                load      = bus.rf_rd_valid;
                load_data = bus.rf_rd_data;
            end
            ST_ALU_WAIT: begin
                load      = bus.alu_out_valid;
                load_data = bus.alu_out[DATA_WIDTH-1:0];
            end
            ST_TX_LO: begin
                load      = tx_done;
                load_data = alu_hi;
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments only, so every register updates from pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= ST_IDLE;
            rf_addr    <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_data <= '0;
            rf_rd_en   <= 1'b0;
            alu_en     <= 1'b0;
            alu_fun    <= '0;
            frame_drop <= 1'b0;
            alu_hi     <= '0;
        end else begin
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            alu_en     <= 1'b0;
            frame_drop <= bus.rx_valid && drops_rx(state);
            case (state)
                ST_IDLE: if (bus.rx_valid) begin
                    case (bus.rx_data)
                        OPC_WR:  state <= ST_WR_ADDR;
                        OPC_RD:  state <= ST_RD_ADDR;
                        OPC_OPS: state <= ST_OP_A;
                        OPC_FUN: state <= ST_ALU_FUN;
                        default: ;
                    endcase
                end
                ST_WR_ADDR: if (bus.rx_valid) begin
                    rf_addr <= bus.rx_data[ADDR_WIDTH-1:0];
                    state   <= ST_WR_DATA;
                end
                ST_WR_DATA: if (bus.rx_valid) begin
                    rf_wr_en   <= 1'b1;
                    rf_wr_data <= bus.rx_data;
                    state      <= ST_IDLE;
                end
                ST_RD_ADDR: if (bus.rx_valid) begin
                    rf_addr  <= bus.rx_data[ADDR_WIDTH-1:0];
                    rf_rd_en <= 1'b1;
                    state    <= ST_RD_WAIT;
                end
                ST_RD_WAIT: if (bus.rf_rd_valid) state <= ST_TX_RD;
                ST_OP_A: if (bus.rx_valid) begin
                    rf_addr    <= ADDR_WIDTH'(OPERAND_A_ADDR);
                    rf_wr_en   <= 1'b1;
                    rf_wr_data <= bus.rx_data;
                    state      <= ST_OP_B;
                end
                ST_OP_B: if (bus.rx_valid) begin
                    rf_addr    <= ADDR_WIDTH'(OPERAND_B_ADDR);
                    rf_wr_en   <= 1'b1;
                    rf_wr_data <= bus.rx_data;
                    state      <= ST_ALU_FUN;
                end
                ST_ALU_FUN: if (bus.rx_valid) begin
                    alu_fun <= bus.rx_data[FUN_WIDTH-1:0];
                    alu_en  <= 1'b1;
                    state   <= ST_ALU_WAIT;
                end
                ST_ALU_WAIT: if (bus.alu_out_valid) begin
                    alu_hi <= bus.alu_out[2*DATA_WIDTH-1:DATA_WIDTH];
                    state  <= ST_TX_LO;
                end
                ST_TX_RD: if (tx_done) state <= ST_IDLE;
                ST_TX_LO: if (tx_done) state <= ST_TX_HI;
                ST_TX_HI: if (tx_done) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    resp_sender #(.DATA_WIDTH(DATA_WIDTH)) u_resp_sender (
        .CLK       (CLK),
        .RST       (RST),
        .load      (load),
        .load_data (load_data),
        .tx_ready  (bus.tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .done      (tx_done)
    );

    assign bus.rf_addr    = rf_addr;
    assign bus.rf_wr_en   = rf_wr_en;
    assign bus.rf_wr_data = rf_wr_data;
    assign bus.rf_rd_en   = rf_rd_en;
    assign bus.alu_en     = alu_en;
    assign bus.alu_fun    = alu_fun;
    assign bus.tx_data    = tx_data;
    assign bus.tx_valid   = tx_valid;
    assign bus.frame_drop = frame_drop;
endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Self-checking bench for sys_cmd_ctrl: directed frames from the test plan
// followed by randomized frames, checked against frame-level expectations.
module tb_sys_cmd_ctrl;
    import sys_cmd_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FW = 4;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    sys_cmd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) bus ();

    sys_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Observed events, sampled mid-cycle on the falling edge.
    int n_wr = 0, n_rd = 0, n_alu = 0, n_drop = 0;
    int tx_obs[$];
    // Expected events derived from the frames sent.
    int e_wr = 0, e_rd = 0, e_alu = 0, e_drop = 0;
    int tx_exp[$];

    always @(negedge CLK) begin
        if (bus.rf_wr_en)   n_wr++;
        if (bus.rf_rd_en)   n_rd++;
        if (bus.alu_en)     n_alu++;
        if (bus.frame_drop) n_drop++;
        if (bus.tx_valid && bus.tx_ready) tx_obs.push_back(int'(bus.tx_data));
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic pause(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ":rf_addr"},    32'(bus.rf_addr),    0);
        check({tag, ":rf_wr_en"},   32'(bus.rf_wr_en),   0);
        check({tag, ":rf_wr_data"}, 32'(bus.rf_wr_data), 0);
        check({tag, ":rf_rd_en"},   32'(bus.rf_rd_en),   0);
        check({tag, ":alu_en"},     32'(bus.alu_en),     0);
        check({tag, ":alu_fun"},    32'(bus.alu_fun),    0);
        check({tag, ":tx_data"},    32'(bus.tx_data),    0);
        check({tag, ":tx_valid"},   32'(bus.tx_valid),   0);
        check({tag, ":frame_drop"}, 32'(bus.frame_drop), 0);
    endtask

    // Let trailing strobes be sampled, then compare all event counts and the TX byte stream.
    task automatic compare_all(input string tag);
        int n;
        pause(2);
        check({tag, ":n_wr"},   n_wr,   e_wr);
        check({tag, ":n_rd"},   n_rd,   e_rd);
        check({tag, ":n_alu"},  n_alu,  e_alu);
        check({tag, ":n_drop"}, n_drop, e_drop);
        check({tag, ":tx_count"}, tx_obs.size(), tx_exp.size());
        n = (tx_obs.size() < tx_exp.size()) ? tx_obs.size() : tx_exp.size();
        for (int i = 0; i < n; i++) check({tag, ":tx_byte"}, tx_obs[i], tx_exp[i]);
        tx_obs.delete();
        tx_exp.delete();
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int g);
        send_byte(OPC_WRITE);
        pause(g);
        send_byte(a);
        pause(g);
        send_byte(d);
        check("wr_en",   32'(bus.rf_wr_en),   1);
        check("wr_addr", 32'(bus.rf_addr),    32'(a[AW-1:0]));
        check("wr_data", 32'(bus.rf_wr_data), 32'(d));
        check("wr_no_tx", 32'(bus.tx_valid),  0);
        e_wr++;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] ret, input int g,
                           input int lat, input int stall, input bit drop_wait, input bit drop_tx);
        bus.tx_ready = 1'b0;
        send_byte(OPC_READ);
        pause(g);
        send_byte(a);
        check("rd_en",   32'(bus.rf_rd_en), 1);
        check("rd_addr", 32'(bus.rf_addr),  32'(a[AW-1:0]));
        e_rd++;
        pause(lat);
        if (drop_wait) begin
            send_byte(OPC_WRITE);
            check("rd_wait_drop", 32'(bus.frame_drop), 1);
            e_drop++;
        end
        bus.rf_rd_data  = ret;
        bus.rf_rd_valid = 1'b1;
        tick();
        bus.rf_rd_valid = 1'b0;
        bus.rf_rd_data  = 8'($urandom);
        check("rd_tx_valid", 32'(bus.tx_valid), 1);
        check("rd_tx_data",  32'(bus.tx_data),  32'(ret));
        for (int i = 0; i < stall; i++) begin
            if (drop_tx && i == 0) begin
                send_byte(8'($urandom));
                check("rd_tx_drop", 32'(bus.frame_drop), 1);
                e_drop++;
            end else begin
                tick();
            end
            check("rd_hold_valid", 32'(bus.tx_valid), 1);
            check("rd_hold_data",  32'(bus.tx_data),  32'(ret));
        end
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        check("rd_tx_done", 32'(bus.tx_valid), 0);
        tx_exp.push_back(int'(ret));
    endtask

    // drop_mode: 0 none, 1 byte during the ALU wait, 2 byte together with alu_out_valid
    task automatic do_alu(input bit with_ops, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] fun, input logic [15:0] ret, input int g,
                          input int lat, input int drop_mode);
        int n;
        bus.tx_ready = 1'b0;
        if (with_ops) begin
            send_byte(OPC_ALU_OPS);
            pause(g);
            send_byte(a);
            check("opa_wr_en",   32'(bus.rf_wr_en),   1);
            check("opa_addr",    32'(bus.rf_addr),    OPERAND_A_ADDR);
            check("opa_data",    32'(bus.rf_wr_data), 32'(a));
            pause(g);
            send_byte(b);
            check("opb_wr_en",   32'(bus.rf_wr_en),   1);
            check("opb_addr",    32'(bus.rf_addr),    OPERAND_B_ADDR);
            check("opb_data",    32'(bus.rf_wr_data), 32'(b));
            e_wr += 2;
        end else begin
            send_byte(OPC_ALU_FUN);
        end
        pause(g);
        send_byte(fun);
        check("alu_en",  32'(bus.alu_en),  1);
        check("alu_fun", 32'(bus.alu_fun), 32'(fun[FW-1:0]));
        e_alu++;
        pause(lat);
        if (drop_mode == 1) begin
            send_byte(8'($urandom));
            check("alu_wait_drop", 32'(bus.frame_drop), 1);
            e_drop++;
        end
        bus.alu_out       = ret;
        bus.alu_out_valid = 1'b1;
        if (drop_mode == 2) begin
            bus.rx_data  = OPC_READ;
            bus.rx_valid = 1'b1;
        end
        tick();
        bus.alu_out_valid = 1'b0;
        bus.rx_valid      = 1'b0;
        bus.alu_out       = 16'($urandom);
        if (drop_mode == 2) begin
            check("alu_same_drop", 32'(bus.frame_drop), 1);
            e_drop++;
        end
        check("alu_tx_valid", 32'(bus.tx_valid), 1);
        check("alu_tx_lo",    32'(bus.tx_data),  32'(ret[7:0]));
        tx_exp.push_back(int'(ret[7:0]));
        tx_exp.push_back(int'(ret[15:8]));
        n = 0;
        while (tx_obs.size() < 2 && n < 60) begin
            bus.tx_ready = ($urandom_range(0, 1) == 1);
            tick();
            n++;
        end
        bus.tx_ready = 1'b0;
        check("alu_tx_done", 32'(bus.tx_valid), 0);
    endtask

    initial begin
        logic [7:0]  a, b, d, fun;
        logic [15:0] ret;
        int          kind;

        bus.rx_data       = '0;
        bus.rx_valid      = 1'b0;
        bus.rf_rd_data    = '0;
        bus.rf_rd_valid   = 1'b0;
        bus.alu_out       = '0;
        bus.alu_out_valid = 1'b0;
        bus.tx_ready      = 1'b0;

        pause(3);
        check_zero_outputs("reset");
        RST = 1'b1;
        tick();

        do_write(8'h05, 8'h3C, 3);
        compare_all("write");

        do_read(8'h05, 8'h3C, 0, 2, 3, 1'b0, 1'b0);
        compare_all("read");

        do_alu(1'b1, 8'h0A, 8'h14, 8'h00, 16'h00C8, 0, 1, 0);
        compare_all("alu_ops");

        do_alu(1'b0, 8'h00, 8'h00, 8'h02, 16'h1234, 0, 0, 0);
        compare_all("alu_fun");

        send_byte(8'h55);
        check("idle_ignore_drop", 32'(bus.frame_drop), 0);
        compare_all("idle_ignore");

        do_alu(1'b0, 8'h00, 8'h00, 8'hF7, 16'hBEEF, 1, 2, 1);
        compare_all("alu_wait_drop");
        do_alu(1'b1, 8'h11, 8'h22, 8'h05, 16'hA55A, 0, 0, 2);
        compare_all("alu_same_cycle_drop");
        do_read(8'hF3, 8'h81, 0, 0, 2, 1'b1, 1'b1);
        compare_all("read_drops");

        send_byte(OPC_WRITE);
        send_byte(8'h07);
        RST = 1'b0;
        tick();
        check_zero_outputs("mid_frame_reset");
        RST = 1'b1;
        do_write(8'h01, 8'h99, 0);
        compare_all("after_reset");

        bus.tx_ready = 1'b0;
        send_byte(OPC_ALU_FUN);
        send_byte(8'h03);
        check("tx_reset_alu_en", 32'(bus.alu_en), 1);
        e_alu++;
        bus.alu_out       = 16'h5AA5;
        bus.alu_out_valid = 1'b1;
        tick();
        bus.alu_out_valid = 1'b0;
        check("tx_reset_valid_before", 32'(bus.tx_valid), 1);
        RST = 1'b0;
        tick();
        check_zero_outputs("tx_reset");
        RST = 1'b1;
        bus.tx_ready = 1'b1;
        pause(4);
        bus.tx_ready = 1'b0;
        compare_all("tx_reset_flush");

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 4);
            a    = 8'($urandom);
            b    = 8'($urandom);
            d    = 8'($urandom);
            fun  = 8'($urandom);
            ret  = 16'($urandom);
            case (kind)
                0: do_write(a, d, $urandom_range(0, 2));
                1: do_read(a, d, $urandom_range(0, 2), $urandom_range(0, 3),
                           $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));
                2: do_alu(1'b1, a, b, fun, ret, $urandom_range(0, 2),
                          $urandom_range(0, 3), $urandom_range(0, 2));
                3: do_alu(1'b0, a, b, fun, ret, $urandom_range(0, 2),
                          $urandom_range(0, 3), $urandom_range(0, 2));
                default: begin
                    while (d == OPC_WRITE || d == OPC_READ || d == OPC_ALU_OPS || d == OPC_ALU_FUN)
                        d = 8'($urandom);
                    send_byte(d);
                    check("rand_idle_drop", 32'(bus.frame_drop), 0);
                end
            endcase
            compare_all("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
